data_bus_master: RTL and testbench



---
 rtl/data_bus_master.sv | 156 +++++++++++++++
 tb/tb_data_bus_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_master.sv
// rtl/data_bus_master.sv - single-outstanding req/gnt/rvalid data bus initiator
// Optional request-to-rvalid timeout abort: define DATA_BUS_MASTER_TIMEOUT_EN.
module data_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [3:0]  cmd_be,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        data_req,
   output logic        data_we,
   output logic [3:0]  data_be,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_gnt,
   input  logic        data_rvalid,
   input  logic [31:0] data_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

   localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

   state_e      state_q;
   logic        cmd_ready_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        data_req_q;
   logic        data_we_q;
   logic [3:0]  data_be_q;
   logic [31:0] data_addr_q;
   logic [31:0] data_wdata_q;
   logic        wr_q;
   logic        timeout_hit;

`ifdef DATA_BUS_MASTER_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] cnt_q;
   logic        rsp_err_q;

   // Held at zero in IDLE so the count restarts on every entry to REQ.
   always_ff @(posedge HCLK) begin
      if (HRESET || state_q == S_IDLE) begin
         cnt_q <= 16'd0;
      end else if (state_q == S_REQ || state_q == S_WAIT) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign timeout_hit = (state_q == S_REQ || state_q == S_WAIT) && (cnt_q == TO_LAST);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         rsp_err_q <= 1'b0;
      end else if (state_q == S_WAIT && data_rvalid) begin
         rsp_err_q <= 1'b0;
      end else if (timeout_hit) begin
         rsp_err_q <= 1'b1;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   logic [15:0] unused_timeout;

   assign unused_timeout = 16'(TIMEOUT_CYCLES);
   assign timeout_hit    = 1'b0;
   assign rsp_err        = 1'b0;
`endif

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q      <= S_IDLE;
         cmd_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= 32'd0;
         data_req_q   <= 1'b0;
         data_we_q    <= 1'b0;
         data_be_q    <= 4'd0;
         data_addr_q  <= 32'd0;
         data_wdata_q <= 32'd0;
         wr_q         <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q  <= 1'b0;
                  wr_q         <= cmd_write;
                  data_req_q   <= 1'b1;
                  data_we_q    <= cmd_write;
                  data_be_q    <= cmd_be;
                  data_addr_q  <= cmd_addr;
                  data_wdata_q <= cmd_wdata;
                  state_q      <= S_REQ;
               end
            end
            S_REQ: begin
               // rvalid is ignored here, including in the grant cycle.
               if (timeout_hit || data_gnt) begin
                  data_req_q   <= 1'b0;
                  data_we_q    <= 1'b0;
                  data_be_q    <= 4'd0;
                  data_addr_q  <= 32'd0;
                  data_wdata_q <= 32'd0;
                  if (timeout_hit) begin
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= ABORT_DATA;
                     state_q     <= S_RESP;
                  end else begin
                     state_q     <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (data_rvalid) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= wr_q ? 32'd0 : data_rdata;
                  state_q     <= S_RESP;
               end else if (timeout_hit) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= ABORT_DATA;
                  state_q     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign data_req   = data_req_q;
   assign data_we    = data_we_q;
   assign data_be    = data_be_q;
   assign data_addr  = data_addr_q;
   assign data_wdata = data_wdata_q;

endmodule

// File: tb/tb_data_bus_master.sv
// tb/tb_data_bus_master.sv - directed self-checking bench for data_bus_master
module tb_data_bus_master;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_be;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        data_req;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;

   int total = 0;
   int bad   = 0;

   data_bus_master #(.TIMEOUT_CYCLES(8)) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_be      (cmd_be),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_be     (data_be),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_gnt    (data_gnt),
      .data_rvalid (data_rvalid),
      .data_rdata  (data_rdata)
   );

   always #5 HCLK = ~HCLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic set_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_be    = be;
      cmd_wdata = wdata;
   endtask

   task automatic zw_read(input string tag, input logic [31:0] addr, input logic [31:0] rd);
      set_cmd(1'b0, addr, 4'hF, 32'd0);
      check_val({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      check_val({tag, "_req"}, 32'(data_req), 32'd1);
      check_val({tag, "_addr"}, data_addr, addr);
      data_gnt = 1'b1;
      step();
      data_gnt    = 1'b0;
      data_rvalid = 1'b1;
      data_rdata  = rd;
      step();
      data_rvalid = 1'b0;
      check_val({tag, "_rspv"}, 32'(rsp_valid), 32'd1);
      check_val({tag, "_rdata"}, rsp_rdata, rd);
      check_val({tag, "_err"}, 32'(rsp_err), 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check_val({tag, "_done"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      HRESET      = 1'b1;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_addr    = 32'd0;
      cmd_be      = 4'd0;
      cmd_wdata   = 32'd0;
      rsp_ready   = 1'b0;
      data_gnt    = 1'b0;
      data_rvalid = 1'b0;
      data_rdata  = 32'd0;

      // reset state
      step();
      step();
      check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("rst_data_req", 32'(data_req), 32'd0);
      check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
      check_val("rst_addr", data_addr, 32'd0);
      HRESET = 1'b0;
      step();
      check_val("idle_cmd_ready", 32'(cmd_ready), 32'd1);

      // stray rvalid while idle
      data_rvalid = 1'b1;
      data_rdata  = 32'h1111_2222;
      step();
      data_rvalid = 1'b0;
      check_val("stray_idle_ready", 32'(cmd_ready), 32'd1);
      check_val("stray_idle_rspv", 32'(rsp_valid), 32'd0);

      // zero-wait read, cycle accurate
      set_cmd(1'b0, 32'h0000_2000, 4'hF, 32'd0);
      check_val("rd_c0_req", 32'(data_req), 32'd0);
      step();
      cmd_valid = 1'b0;
      check_val("rd_c1_req", 32'(data_req), 32'd1);
      check_val("rd_c1_we", 32'(data_we), 32'd0);
      check_val("rd_c1_addr", data_addr, 32'h0000_2000);
      check_val("rd_c1_ready", 32'(cmd_ready), 32'd0);
      data_gnt = 1'b1;
      step();
      data_gnt = 1'b0;
      check_val("rd_c2_req", 32'(data_req), 32'd0);
      check_val("rd_c2_rspv", 32'(rsp_valid), 32'd0);
      data_rvalid = 1'b1;
      data_rdata  = 32'h0000_A5C3;
      step();
      data_rvalid = 1'b0;
      check_val("rd_c3_rspv", 32'(rsp_valid), 32'd1);
      check_val("rd_c3_rdata", rsp_rdata, 32'h0000_A5C3);
      check_val("rd_c3_err", 32'(rsp_err), 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check_val("rd_c4_rspv", 32'(rsp_valid), 32'd0);
      check_val("rd_c4_ready", 32'(cmd_ready), 32'd1);

      // write with grant delayed 3 cycles
      set_cmd(1'b1, 32'h0000_2004, 4'hF, 32'h0000_1234);
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("wr_req%0d", i), 32'(data_req), 32'd1);
         check_val($sformatf("wr_we%0d", i), 32'(data_we), 32'd1);
         check_val($sformatf("wr_addr%0d", i), data_addr, 32'h0000_2004);
         check_val($sformatf("wr_wdata%0d", i), data_wdata, 32'h0000_1234);
         check_val($sformatf("wr_be%0d", i), 32'(data_be), 32'hF);
         data_gnt = (i == 3);
         step();
      end
      data_gnt = 1'b0;
      check_val("wr_c5_req", 32'(data_req), 32'd0);
      data_rvalid = 1'b1;
      data_rdata  = 32'hFFFF_0000;
      step();
      data_rvalid = 1'b0;
      check_val("wr_c6_rspv", 32'(rsp_valid), 32'd1);
      check_val("wr_c6_rdata", rsp_rdata, 32'd0);

      // back-pressure with a pending read command
      set_cmd(1'b0, 32'h0000_3000, 4'h3, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         check_val($sformatf("bp_rspv%0d", i), 32'(rsp_valid), 32'd1);
         check_val($sformatf("bp_rdata%0d", i), rsp_rdata, 32'd0);
         check_val($sformatf("bp_ready%0d", i), 32'(cmd_ready), 32'd0);
         check_val($sformatf("bp_req%0d", i), 32'(data_req), 32'd0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check_val("bp_after_ready", 32'(cmd_ready), 32'd1);
      check_val("bp_after_req", 32'(data_req), 32'd0);
      step();
      cmd_valid = 1'b0;
      check_val("bp_next_req", 32'(data_req), 32'd1);
      check_val("bp_next_addr", data_addr, 32'h0000_3000);
      check_val("bp_next_be", 32'(data_be), 32'h3);

      // stray rvalid in REQ before grant
      data_rvalid = 1'b1;
      data_rdata  = 32'h0000_BAD0;
      step();
      data_rvalid = 1'b0;
      check_val("stray_req_req", 32'(data_req), 32'd1);
      check_val("stray_req_rspv", 32'(rsp_valid), 32'd0);
      data_gnt = 1'b1;
      step();
      data_gnt = 1'b0;
      data_rvalid = 1'b1;
      data_rdata  = 32'h5566_7788;
      step();
      data_rvalid = 1'b0;
      check_val("stray_rspv", 32'(rsp_valid), 32'd1);
      check_val("stray_rdata", rsp_rdata, 32'h5566_7788);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // reset while in WAIT, then a late rvalid
      set_cmd(1'b0, 32'h0000_4000, 4'hF, 32'd0);
      step();
      cmd_valid = 1'b0;
      data_gnt = 1'b1;
      step();
      data_gnt = 1'b0;
      HRESET = 1'b1;
      step();
      HRESET = 1'b0;
      check_val("mrst_ready", 32'(cmd_ready), 32'd0);
      check_val("mrst_req", 32'(data_req), 32'd0);
      check_val("mrst_rspv", 32'(rsp_valid), 32'd0);
      check_val("mrst_rdata", rsp_rdata, 32'd0);
      data_rvalid = 1'b1;
      data_rdata  = 32'h7777_7777;
      step();
      data_rvalid = 1'b0;
      check_val("mrst_late_rspv", 32'(rsp_valid), 32'd0);
      check_val("mrst_late_ready", 32'(cmd_ready), 32'd1);
      zw_read("mrst_next", 32'h0000_4004, 32'h0BAD_CAFE);

      // never-granting responder
      set_cmd(1'b0, 32'h0000_5000, 4'hF, 32'd0);
      step();
      cmd_valid = 1'b0;
`ifdef DATA_BUS_MASTER_TIMEOUT_EN
      begin
         int n;
         n = 0;
         while (data_req && n < 20) begin
            n++;
            step();
         end
         check_val("to_req_cycles", 32'(n), 32'd8);
         check_val("to_rspv", 32'(rsp_valid), 32'd1);
         check_val("to_err", 32'(rsp_err), 32'd1);
         check_val("to_rdata", rsp_rdata, 32'hDEAD_BEEF);
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
         check_val("to_done", 32'(rsp_valid), 32'd0);
      end
`else
      for (int i = 0; i < 1000; i++) step();
      check_val("noto_req", 32'(data_req), 32'd1);
      check_val("noto_rspv", 32'(rsp_valid), 32'd0);
      check_val("noto_ready", 32'(cmd_ready), 32'd0);
      check_val("noto_err", 32'(rsp_err), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
